// File: rtl/riscv_perf_counter_unit.sv
// ---------------------------------------------------------------------------
// riscv_perf_counter_unit
//
// Hardware performance-monitoring unit for the RI5CY core. It sits beside the
// CSR file and provides N_CNT event counters of CNT_WIDTH bits. Each counter
// has its own run-time event selector. Counters either wrap or saturate, and
// set sticky overflow flags that can raise an interrupt. Counters wider than
// 32 bits are read atomically: reading the low half captures the high half
// into a snapshot register.
//
// Ports
//   clk           core clock
//   rst           synchronous, active-high reset
//   csr_access_i  a CSR access is happening this cycle (gates all decode)
//   csr_addr_i    CSR address
//   csr_wdata_i   CSR write operand
//   csr_op_i      0 NONE, 1 WRITE, 2 SET, 3 CLEAR
//   csr_rdata_o   read data for a hit, 0 otherwise (combinational)
//   csr_hit_o     the address belongs to this unit
//   events_i      single-cycle event pulses
//   irq_o         overflow interrupt request
//
// CSR map
//   0x7A0 CTRL (bit0 enable, bit1 saturate, bit2 irq enable)
//   0x7A1 OVF
//   0x7A2 CNTEN
//   0x7A3 SNAP (read-only)
//   0x780+i counter i [31:0]
//   0x790+i counter i upper bits
//   0x7D0+i EVSEL i
// ---------------------------------------------------------------------------
module riscv_perf_counter_unit #(
  parameter int N_CNT     = 4,
  parameter int CNT_WIDTH = 48,
  parameter int N_EVENTS  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                csr_access_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [31:0]         csr_wdata_i,
  input  logic [1:0]          csr_op_i,
  output logic [31:0]         csr_rdata_o,
  output logic                csr_hit_o,
  input  logic [N_EVENTS-1:0] events_i,
  output logic                irq_o
);

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SET   = 2'd2,
    OP_CLEAR = 2'd3
  } csr_op_e;

  logic [2:0]           ctrl_q,  ctrl_d;
  logic [N_CNT-1:0]     ovf_q,   ovf_d;
  logic [N_CNT-1:0]     cnten_q, cnten_d;
  logic [31:0]          snap_q,  snap_d;
  logic [N_EVENTS-1:0]  evt_q;
  logic [CNT_WIDTH-1:0] cnt_q   [N_CNT];
  logic [CNT_WIDTH-1:0] cnt_d   [N_CNT];
  logic [6:0]           evsel_q [N_CNT];
  logic [6:0]           evsel_d [N_CNT];

  // ---------------------------------------------------------------- decode
  logic [3:0] idx;
  logic       idx_ok;
  logic       sel_ctrl, sel_ovf, sel_cnten, sel_snap, sel_lo, sel_hi, sel_evsel;
  logic       do_write;

  assign idx       = csr_addr_i[3:0];
  assign idx_ok    = ({1'b0, idx} < 5'(N_CNT));
  assign sel_ctrl  = (csr_addr_i == 12'h7A0);
  assign sel_ovf   = (csr_addr_i == 12'h7A1);
  assign sel_cnten = (csr_addr_i == 12'h7A2);
  assign sel_snap  = (csr_addr_i == 12'h7A3);
  assign sel_lo    = (csr_addr_i[11:4] == 8'h78) && idx_ok;
  assign sel_hi    = (csr_addr_i[11:4] == 8'h79) && idx_ok;
  assign sel_evsel = (csr_addr_i[11:4] == 8'h7D) && idx_ok;

  assign csr_hit_o = csr_access_i &
                     (sel_ctrl | sel_ovf | sel_cnten | sel_snap | sel_lo | sel_hi | sel_evsel);
  assign do_write  = csr_hit_o && (csr_op_i != OP_NONE);

  // ---------------------------------------------------------------- read mux
  // The selected counter is zero-extended to 64 bits so both halves can be
  // sliced uniformly whatever CNT_WIDTH is.
  logic [63:0] rd_cnt;
  logic [6:0]  rd_evsel;
  logic [31:0] rd_val;
  logic [31:0] wr_val;

  always_comb begin
    rd_cnt   = '0;
    rd_evsel = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (idx == 4'(i)) begin
        rd_cnt   = 64'(cnt_q[i]);
        rd_evsel = evsel_q[i];
      end
    end

    rd_val = '0;
    if (sel_ctrl)       rd_val = {29'd0, ctrl_q};
    else if (sel_ovf)   rd_val = 32'(ovf_q);
    else if (sel_cnten) rd_val = 32'(cnten_q);
    else if (sel_snap)  rd_val = snap_q;
    else if (sel_lo)    rd_val = rd_cnt[31:0];
    else if (sel_hi)    rd_val = rd_cnt[63:32];
    else if (sel_evsel) rd_val = {25'd0, rd_evsel};

    // Read-modify-write operand; unimplemented bits fall away when the
    // result is narrowed into the target register.
    case (csr_op_i)
      OP_WRITE: wr_val = csr_wdata_i;
      OP_SET:   wr_val = csr_wdata_i | rd_val;
      OP_CLEAR: wr_val = ~csr_wdata_i & rd_val;
      default:  wr_val = rd_val;
    endcase
  end

  assign csr_rdata_o = csr_hit_o ? rd_val : 32'd0;
  assign irq_o       = ctrl_q[2] & (|ovf_q);

  // ---------------------------------------------------------------- increment enables
  // Events are zero-padded to 128 so any 7-bit selector indexes safely; the
  // explicit range check keeps out-of-range selectors from ever counting.
  logic [127:0]     evt_ext;
  logic [N_CNT-1:0] inc;

  assign evt_ext = 128'(evt_q);

  for (genvar gi = 0; gi < N_CNT; gi++) begin : g_inc
    assign inc[gi] = ctrl_q[0] & cnten_q[gi] &
                     ({1'b0, evsel_q[gi]} < 8'(N_EVENTS)) &
                     evt_ext[evsel_q[gi]];
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    ctrl_d  = ctrl_q;
    cnten_d = cnten_q;
    ovf_d   = ovf_q;
    snap_d  = snap_q;

    if (do_write && sel_ctrl)  ctrl_d  = wr_val[2:0];
    if (do_write && sel_cnten) cnten_d = wr_val[N_CNT-1:0];
    // Software update first; hardware overflow sets below OR on top so a
    // simultaneous set beats a clear.
    if (do_write && sel_ovf)   ovf_d   = wr_val[N_CNT-1:0];
    // Any access to a low half captures the matching high half.
    if (csr_hit_o && sel_lo)   snap_d  = rd_cnt[63:32];

    for (int i = 0; i < N_CNT; i++) begin
      logic [63:0] wr_ext;
      logic        wr_lo, wr_hi;
      wr_ext      = 64'(cnt_q[i]);
      wr_lo       = do_write && sel_lo && (idx == 4'(i));
      wr_hi       = do_write && sel_hi && (idx == 4'(i));
      cnt_d[i]    = cnt_q[i];
      evsel_d[i]  = evsel_q[i];

      if (do_write && sel_evsel && (idx == 4'(i))) evsel_d[i] = wr_val[6:0];

      if (wr_lo || wr_hi) begin
        // A CSR write wins over a same-cycle increment; the untouched half
        // keeps its value.
        if (wr_lo) wr_ext[31:0]  = wr_val;
        if (wr_hi) wr_ext[63:32] = wr_val;
        cnt_d[i] = wr_ext[CNT_WIDTH-1:0];
      end else if (inc[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = ctrl_q[1] ? {CNT_WIDTH{1'b1}} : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= 3'b011;
      ovf_q   <= '0;
      cnten_q <= '1;
      snap_q  <= '0;
      evt_q   <= '0;
      for (int i = 0; i < N_CNT; i++) begin
        cnt_q[i]   <= '0;
        evsel_q[i] <= 7'(i % N_EVENTS);
      end
    end else begin
      ctrl_q  <= ctrl_d;
      ovf_q   <= ovf_d;
      cnten_q <= cnten_d;
      snap_q  <= snap_d;
      evt_q   <= events_i;
      for (int i = 0; i < N_CNT; i++) begin
        cnt_q[i]   <= cnt_d[i];
        evsel_q[i] <= evsel_d[i];
      end
    end
  end

endmodule
